// File: rtl/msg_buffer_writer.sv
// Character-stream to packed message buffer with padding and commit to MSG.
// Define MSG_WRITER_VSYNC_SYNC_EN to hold each commit until a frame_start pulse.
module msg_buffer_writer #(
    parameter int         MSG_LENGTH = 6,
    parameter logic [7:0] FILL_CHAR  = 8'h20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [7:0]                wr_char,
    input  logic                      wr_last,
    input  logic                      clear,
    input  logic                      frame_start,
    output logic [0:8*MSG_LENGTH-1]   MSG,
    output logic                      busy,
    output logic                      done,
    output logic                      truncated
);

    localparam int PW = $clog2(MSG_LENGTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(MSG_LENGTH);
    localparam logic [PW-1:0] ONE_PTR  = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_PAD,
        S_DROP,
        S_PEND
    } state_t;

    state_t                          state_q, state_d;
    logic [PW-1:0]                   ptr_q, ptr_d;
    logic [MSG_LENGTH-1:0][7:0]      shadow_q, shadow_d;
    logic [0:8*MSG_LENGTH-1]         msg_q, msg_d;
    logic                            trunc_pend_q, trunc_pend_d;
    logic                            truncated_q, truncated_d;
    logic                            done_q, done_d;
    logic                            xfer;
    logic                            commit_ok;
    logic [PW-1:0]                   ptr_inc;

    // Shared next-state rule after a character lands; p is the post-increment pointer.
    function automatic state_t after_write(input logic [PW-1:0] p, input logic last);
        if (p == LAST_PTR) return last ? S_PEND : S_DROP;
        return last ? S_PAD : S_WRITE;
    endfunction

`ifdef MSG_WRITER_VSYNC_SYNC_EN
    assign commit_ok = frame_start;
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    assign commit_ok = 1'b1;
`endif

    assign wr_ready = (state_q == S_IDLE || state_q == S_WRITE || state_q == S_DROP) && !clear;
    assign xfer     = wr_valid && wr_ready;
    assign ptr_inc  = ptr_q + ONE_PTR;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        shadow_d     = shadow_q;
        msg_d        = msg_q;
        trunc_pend_d = trunc_pend_q;
        truncated_d  = truncated_q;
        done_d       = 1'b0;
        if (clear) begin
            state_d      = S_IDLE;
            ptr_d        = '0;
            trunc_pend_d = 1'b0;
            shadow_d     = {MSG_LENGTH{FILL_CHAR}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (xfer) begin
                        shadow_d[0] = wr_char;
                        ptr_d       = ONE_PTR;
                        state_d     = after_write(ONE_PTR, wr_last);
                    end
                end
                S_WRITE: begin
                    if (xfer) begin
                        for (int i = 0; i < MSG_LENGTH; i++)
                            if (ptr_q == PW'(i)) shadow_d[i] = wr_char;
                        ptr_d   = ptr_inc;
                        state_d = after_write(ptr_inc, wr_last);
                    end
                end
                S_PAD: begin
                    for (int i = 0; i < MSG_LENGTH; i++)
                        if (ptr_q == PW'(i)) shadow_d[i] = FILL_CHAR;
                    ptr_d = ptr_inc;
                    if (ptr_inc == LAST_PTR) state_d = S_PEND;
                end
                S_DROP: begin
                    if (xfer && wr_last) begin
                        state_d      = S_PEND;
                        trunc_pend_d = 1'b1;
                    end
                end
                S_PEND: begin
                    if (commit_ok) begin
                        for (int i = 0; i < MSG_LENGTH; i++)
                            msg_d[8*i +: 8] = shadow_q[i];
                        truncated_d  = trunc_pend_q;
                        done_d       = 1'b1;
                        state_d      = S_IDLE;
                        ptr_d        = '0;
                        trunc_pend_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            shadow_q     <= {MSG_LENGTH{FILL_CHAR}};
            msg_q        <= {MSG_LENGTH{FILL_CHAR}};
            trunc_pend_q <= 1'b0;
            truncated_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            shadow_q     <= shadow_d;
            msg_q        <= msg_d;
            trunc_pend_q <= trunc_pend_d;
            truncated_q  <= truncated_d;
            done_q       <= done_d;
        end
    end

    assign MSG       = msg_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign truncated = truncated_q;

endmodule

// File: tb/tb_msg_buffer_writer.sv
// Directed bench for msg_buffer_writer (MSG_LENGTH=6); follows MSG_WRITER_VSYNC_SYNC_EN.
module tb_msg_buffer_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_char = 8'h00;
    logic        wr_last = 1'b0;
    logic        clear = 1'b0;
    logic        frame_start = 1'b0;
    logic [0:47] MSG;
    logic        busy;
    logic        done;
    logic        truncated;

    int n_vec  = 0;
    int n_miss = 0;

    msg_buffer_writer #(.MSG_LENGTH(6), .FILL_CHAR(8'h20)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_char     (wr_char),
        .wr_last     (wr_last),
        .clear       (clear),
        .frame_start (frame_start),
        .MSG         (MSG),
        .busy        (busy),
        .done        (done),
        .truncated   (truncated)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends s; wr_last is raised on the final character when last is set.
    task automatic send(input string s, input bit last);
        for (int i = 0; i < s.len(); i++) begin
            wr_valid = 1'b1;
            wr_char  = s[i];
            wr_last  = last && (i == s.len() - 1);
            #0;
            chk("wr_ready_accept", {63'd0, wr_ready}, 64'd1);
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Drives the message to commit and checks the edge on which done appears.
    task automatic commit(input int exp_lat, input logic [47:0] prev_msg);
`ifdef MSG_WRITER_VSYNC_SYNC_EN
        int seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) seen_done++;
        end
        chk("no_commit_before_frame", {16'd0, MSG}, {16'd0, prev_msg});
        chk("no_done_before_frame", 64'(seen_done), 64'd0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("done_at_frame", {63'd0, done}, 64'd1);
        if (exp_lat < 0) chk("lat_unused", 64'd0, 64'd1);
`else
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("commit_latency", 64'(n), 64'(exp_lat));
        if (prev_msg === 48'hx) chk("prev_msg_unused", 64'd0, 64'd1);
`endif
        tick();
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("idle_after_commit", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_msg", {16'd0, MSG}, {16'd0, "      "});
        chk("rst_ready", {63'd0, wr_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_trunc", {63'd0, truncated}, 64'd0);

        // Short message: 2 chars, 4 pad cycles then commit.
        send("HI", 1'b1);
        chk("hi_busy", {63'd0, busy}, 64'd1);
        chk("hi_pad_not_ready", {63'd0, wr_ready}, 64'd0);
        chk("hi_msg_before", {16'd0, MSG}, {16'd0, "      "});
        commit(5, "      ");
        chk("hi_msg", {16'd0, MSG}, {16'd0, "HI    "});

        send("WIN", 1'b1);
        commit(4, "HI    ");
        chk("win_msg", {16'd0, MSG}, {16'd0, "WIN   "});
        chk("win_trunc", {63'd0, truncated}, 64'd0);

        // Exact fit goes straight to pending.
        send("X WINS", 1'b1);
        commit(1, "WIN   ");
        chk("fit_msg", {16'd0, MSG}, {16'd0, "X WINS"});

        // Overlong message is truncated, then a short one clears the flag.
        send("DRAWGAME!", 1'b1);
        commit(1, "X WINS");
        chk("long_msg", {16'd0, MSG}, {16'd0, "DRAWGA"});
        chk("long_trunc", {63'd0, truncated}, 64'd1);
        send("OK", 1'b1);
        commit(5, "DRAWGA");
        chk("ok_msg", {16'd0, MSG}, {16'd0, "OK    "});
        chk("ok_trunc", {63'd0, truncated}, 64'd0);

        // Clear mid-message: 'C' refused, shadow wiped, next message starts at cell 0.
        send("AB", 1'b0);
        wr_valid = 1'b1;
        wr_char  = "C";
        clear    = 1'b1;
        #0;
        chk("clear_not_ready", {63'd0, wr_ready}, 64'd0);
        tick();
        clear    = 1'b0;
        wr_valid = 1'b0;
        chk("clear_idle", {63'd0, busy}, 64'd0);
        chk("clear_msg_kept", {16'd0, MSG}, {16'd0, "OK    "});
        send("Z", 1'b1);
        commit(6, "OK    ");
        chk("after_clear_msg", {16'd0, MSG}, {16'd0, "Z     "});

`ifdef MSG_WRITER_VSYNC_SYNC_EN
        // Frame pulse during padding is missed.
        send("O", 1'b1);
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("missed_frame_no_done", {63'd0, done}, 64'd0);
        commit(0, "Z     ");
        chk("missed_frame_msg", {16'd0, MSG}, {16'd0, "O     "});
`endif

        // Asynchronous reset while pending.
        send("ABCDEFGH", 1'b1);
        commit(1, "Z     ");
        chk("pre_rst_trunc", {63'd0, truncated}, 64'd1);
        send("Q", 1'b1);
        repeat (5) tick();
        chk("pend_busy", {63'd0, busy}, 64'd1);
        chk("pend_not_ready", {63'd0, wr_ready}, 64'd0);
        rst_n = 1'b0;
        #2;
        chk("arst_msg", {16'd0, MSG}, {16'd0, "      "});
        chk("arst_trunc", {63'd0, truncated}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        tick();
        rst_n = 1'b1;
        chk("arst_ready", {63'd0, wr_ready}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/msg_buffer_writer.md
# msg_buffer_writer

Producer side of the text-overlay path: accepts a character stream over a valid/ready handshake, assembles it into a shadow buffer, pads unused positions, and commits the finished string to the packed `MSG` bus consumed by the message renderer. The commit is frame-synchronized, so the renderer never shows a half-written string. It sits between game/control logic (or a UART command parser) and the VGA text layer.

## Interface
Parameters:
- `MSG_LENGTH`, 6, number of character cells; must be ≥ 1.
- `FILL_CHAR`, 8'h20, ASCII code written to unused cells.

Ports:
- `clk`  input  1  pixel-domain clock. Everything is in this single clock domain.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `wr_valid`  input  1  `wr_char` is valid.
- `wr_ready`  output  1  block accepts a character this cycle.
- `wr_char`  input  8  ASCII character.
- `wr_last`  input  1  qualifies the final character of a message.
- `clear`  input  1  synchronous abort. Clears the shadow buffer.
- `frame_start`  input  1  one-cycle pulse at the start of vertical blanking.
- `MSG`  output  [0:8*MSG_LENGTH-1]  committed string. Character i is at `MSG[8*i +: 8]`; index 0 is leftmost on screen.
- `busy`  output  1  high in every state except S_IDLE.
- `done`  output  1  one-cycle pulse on the cycle `MSG` updates.
- `truncated`  output  1  sticky flag: the last committed message was longer than `MSG_LENGTH`.

## Operation
- **Handshake.** A transfer occurs when `wr_valid && wr_ready` at a rising edge.
- **`wr_ready`.** Combinational: `(state==S_IDLE || state==S_WRITE || state==S_DROP) && !clear`.
- **Shadow buffer and pointer.** The shadow buffer has `MSG_LENGTH` bytes. Pointer `ptr` is `$clog2(MSG_LENGTH+1)` bits wide.
- **S_IDLE.** A transfer writes `shadow[0]` and sets `ptr=1`. Next state is chosen by the rule below.
- **S_WRITE.** A transfer writes `shadow[ptr]` and increments `ptr`. Next-state rule, evaluated on the post-increment `ptr`:
  - `wr_last` and `ptr<MSG_LENGTH`: go to S_PAD.
  - `wr_last` and `ptr==MSG_LENGTH`: go to S_PEND.
  - `!wr_last` and `ptr==MSG_LENGTH`: go to S_DROP.
  - Otherwise: stay in S_WRITE.
- **S_PAD.** Writes `FILL_CHAR` to `shadow[ptr]` once per cycle and increments `ptr`. Goes to S_PEND when `ptr` reaches `MSG_LENGTH`. `wr_ready` is 0.
- **S_DROP.** Accepts and discards characters. A transfer with `wr_last` goes to S_PEND with `trunc_pending=1`.
- **S_PEND.** `wr_ready=0`.
  - When `frame_start` is sampled high: `MSG <= shadow`, `truncated <= trunc_pending`, `done` pulses, and the state returns to S_IDLE.
  - Then `ptr=0` and `trunc_pending=0`.
- **`clear`.** Acts in any state and has priority over everything else:
  - Next state S_IDLE; `ptr=0`; `trunc_pending=0`.
  - All shadow bytes become `FILL_CHAR` in one cycle.
  - `MSG` and `truncated` are unchanged.
- **Single-character message.** `wr_last` on the S_IDLE transfer with `MSG_LENGTH>1` goes to S_PAD. With `MSG_LENGTH==1` it goes to S_PEND.
- **`frame_start` outside S_PEND.** Ignored. A pulse during S_PAD is missed, and the commit waits for the next frame.

## Timing
- **Reset values:**
  - State S_IDLE, so `wr_ready=1` once `rst_n` is high.
  - Every `MSG` byte and every shadow byte = `FILL_CHAR`.
  - `busy=0`, `done=0`, `truncated=0`, `ptr=0`.
- **Reset mid-operation.** Asserting `rst_n` low restores the reset values immediately (asynchronous). The partial message is lost.
- **Pad latency.** A k-character message with `wr_last` accepted at edge t, where k<`MSG_LENGTH`:
  - S_PAD for `MSG_LENGTH-k` cycles.
  - S_PEND is entered at edge t+`MSG_LENGTH-k`.
- **Commit latency.** `MSG` and `done` change at the edge that samples `frame_start` in S_PEND. `done` is high for exactly one cycle.
- **Back-to-back messages.** A new message may start the cycle after `done`.
- **Other outputs.** `MSG`, `done` and `truncated` are registered. `wr_ready` and `busy` are decoded from state.

## Configuration
- `MSG_WRITER_VSYNC_SYNC_EN` defined:
  - The commit waits for `frame_start`, as described above.
- `MSG_WRITER_VSYNC_SYNC_EN` undefined:
  - `frame_start` is ignored.
  - S_PEND commits unconditionally on its first cycle, so `MSG` updates one cycle after S_PEND is entered.
  - All other behaviour is identical.

## Test plan
Unless stated otherwise, `MSG_LENGTH=6` and the macro is defined.
- **Short message.** Reset, then send "WIN" with `wr_last` on 'N', then pulse `frame_start` 10 cycles later → `MSG`="WIN   ", `done` one pulse, `truncated=0`. Before the pulse, `MSG`="      ".
- **Exact fit.** Send the 6 characters "X WINS" with `wr_last` on the 6th → no S_PAD cycles; commit on the next `frame_start`; `MSG`="X WINS".
- **Overlong message.** Send 9 characters "DRAWGAME!" with `wr_last` on the 9th → all 9 accepted; `MSG`="DRAWGA"; `truncated=1`. A following 2-character message clears `truncated` to 0.
- **Clear mid-message.** Send "AB", pulse `clear` together with `wr_valid` on 'C' → 'C' is not accepted (`wr_ready=0`); state is S_IDLE; `MSG` is unchanged. The next message then starts at cell 0.
- **Missed frame.** Send "O" with `wr_last`, pulse `frame_start` 2 cycles later (still in S_PAD) → no commit. The second `frame_start`, sampled in S_PEND, commits "O     ".
- **Asynchronous reset.** Drive `rst_n` low mid-S_PEND → outputs return to their reset values without a clock edge.
- **Macro undefined.** Send "HI" with `wr_last` and no `frame_start` → `MSG`="HI    " and `done` one cycle after S_PEND is entered, at the 5th edge after `wr_last` (4 S_PAD cycles, 1 S_PEND cycle).
